data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Arbiter and sequencer for the single-ported data memory shared by the pipeline memory stage (load/store/push/pop/store-framebuffer) and the video framebuffer fetch engine. It grants one memory access per cycle, posts CPU writes into a one-entry write buffer so stores do not stall, and routes synchronous read data back to the correct requester. It sits between the execute/memory stage, after memory forwarding selects write data, and the data RAM.

## Interface
- `ADDR_WIDTH`, 16, word address width.
- `DATA_WIDTH`, 16, word width; split into top and bottom bytes.
- `MAX_WAIT`, 7, cycles the video requester may be denied before it is forced to win; must be at least 1.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `cpu_req`  in  1  memory-stage access request.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_WIDTH  word address.
- `cpu_wdata`  in  DATA_WIDTH  write data.
- `cpu_be`  in  2  byte enables; [1] = top, [0] = bottom.
- `cpu_stall`  out  1  hold the pipeline; request not accepted this cycle.
- `cpu_rdata`  out  DATA_WIDTH  load data.
- `cpu_rvalid`  out  1  `cpu_rdata` is valid.
- `vid_req`  in  1  framebuffer read request.
- `vid_addr`  in  ADDR_WIDTH  read address.
- `vid_gnt`  out  1  read issued this cycle.
- `vid_rdata`  out  DATA_WIDTH  read data.
- `vid_rvalid`  out  1  `vid_rdata` is valid.
- `mem_en`, `mem_we`  out  1  RAM enable and write strobe.
- `mem_be`  out  2  RAM byte enables.
- `mem_addr`  out  ADDR_WIDTH  RAM address.
- `mem_wdata`  out  DATA_WIDTH  RAM write data.
- `mem_rdata`  in  DATA_WIDTH  RAM read data, one cycle after a read is issued.

## Operation
- Internal state:
  - write buffer `wb_valid`, `wb_addr`, `wb_data`, `wb_be`;
  - video wait counter `vwait`, saturating at `MAX_WAIT`;
  - read-owner tag `rd_owner` ∈ {NONE, CPU, VID}.
- Per-cycle slot priority, highest first:
  1. Video starved: `vid_req`, `vwait == MAX_WAIT`, and not (`wb_valid` and `vid_addr == wb_addr`).
  2. Write-buffer drain: `wb_valid`.
  3. CPU direct access: `cpu_req`.
  4. Video: `vid_req`.
- CPU write acceptance:
  - Accepted (no stall) if it wins the slot, goes directly to the RAM, and the buffer stays untouched.
  - Otherwise posted into the buffer if the buffer is empty, or is draining this same cycle.
  - Otherwise stalls.
- CPU read:
  - Stalls whenever `wb_valid` is set at the start of the cycle; the drain always precedes the read, so no read-after-write forwarding is needed.
  - Otherwise accepted only if it wins the slot.
- `cpu_stall` = `cpu_req` & ~accepted. It is combinational and never asserted without `cpu_req`.
- A video read stalls while a buffered write to the same address is pending.
- `vwait` update each cycle:
  - Cleared when video is granted.
  - Incremented when `vid_req` is set and video is denied.
  - Held otherwise.
- `cpu_be == 2'b00` on a write is accepted as a no-op: no RAM write and no buffer entry.

## Timing
- Read issued at cycle N (`mem_en`=1, `mem_we`=0). `rd_owner` is registered at N.
- At N+1, `mem_rdata` is muxed to the owner's `*_rdata`, and the owner's `*_rvalid` is pulsed for one cycle.
- Back-to-back reads are allowed every cycle; there is no bubble.
- A CPU write is visible in the RAM at:
  - the same edge, if it goes direct;
  - the edge at the end of the drain cycle, if posted. The earliest drain is the cycle after posting.
- Reset values:
  - all `mem_*` = 0; `cpu_rvalid` = `vid_rvalid` = 0; `vid_gnt` = 0;
  - `wb_valid` = 0, `vwait` = 0, `rd_owner` = NONE.
- Reset asserted mid-read: the pending `rvalid` at the next cycle is suppressed, and the buffered write is discarded.
- Simultaneous drain and CPU write in the same cycle: the old entry goes to the RAM, and the new entry is loaded; `wb_valid` stays 1.

## Structure
- Shared package/header `data_mem_arb_pkg`:
  - owner encodings `OWN_NONE`/`OWN_CPU`/`OWN_VID`;
  - slot-grant encodings;
  - byte-enable constants `BE_TOP`/`BE_BOT`/`BE_WORD`.
- One sub-module, `posted_write_buffer`: the single-entry register with load, drain and address-compare ports.
- Priority select, `vwait` counter and read-return mux live in the top level.

## Test plan
- Lone CPU read: addr 0x0040 with RAM holding 0xBEEF. Required: `cpu_stall`=0, `mem_en`=1 at N, `cpu_rvalid`=1 with `cpu_rdata`=0xBEEF at N+1.
- CPU write while video holds the slot through starvation (`vwait`=7):
  - Write 0x1234 to 0x0010. Required: no stall, `wb_valid`=1.
  - Next cycle the drain shows `mem_we`=1, addr 0x0010, data 0x1234.
- CPU read following a posted write: `cpu_stall`=1 for exactly one cycle (drain), then the read issues and returns the new data.
- Starvation with CPU reads every cycle and `vid_req` held:
  - Required: `vid_gnt` on the 8th cycle (`vwait` reaches 7); `vwait` returns to 0.
  - `vid_rvalid` asserts the following cycle.
- Second write with the buffer full and not draining (video starved): `cpu_stall`=1 until the drain cycle. Then posting and drain happen in the same cycle, and `wb_valid` stays 1.
- Reset asserted the cycle after a video read issue: `vid_rvalid`=0, and all outputs at reset values the next cycle.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared encodings for the data memory arbiter: read owners, slot grants, byte enables.
package data_mem_arb_pkg;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_VID  = 2'd2;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_VID  = 2'd1;
  localparam logic [1:0] GNT_WB   = 2'd2;
  localparam logic [1:0] GNT_CPU  = 2'd3;

  localparam logic [1:0] BE_TOP  = 2'b10;
  localparam logic [1:0] BE_BOT  = 2'b01;
  localparam logic [1:0] BE_WORD = 2'b11;

endpackage

// File: rtl/posted_write_buffer.sv
// Single-entry posted write register; load wins over drain so a same-cycle
// drain+post leaves the entry valid with the new contents.
module posted_write_buffer
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [1:0]            load_be,
  input  logic                  drain,
  input  logic [ADDR_WIDTH-1:0] cmp_addr,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            be,
  output logic                  hit
);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
      be    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
      be    <= load_be;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (cmp_addr == addr);

endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data RAM arbiter: CPU memory stage vs video fetch, with a posted
// CPU write buffer, starvation guard for video and registered read-return routing.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WAIT   = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [1:0]            cpu_be,
  output logic                  cpu_stall,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_gnt,
  output logic [DATA_WIDTH-1:0] vid_rdata,
  output logic                  vid_rvalid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [1:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int            VW   = $clog2(MAX_WAIT + 1);
  localparam logic [VW-1:0] VMAX = VW'(MAX_WAIT);

  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [1:0]            wb_be;
  logic                  wb_hit;
  logic                  wb_load;
  logic                  wb_drain;

  logic [VW-1:0] vwait;
  logic [1:0]    rd_owner;
  logic [1:0]    slot;
  logic          cpu_noop;
  logic          vid_starved;
  logic          cpu_accept;

  assign cpu_noop    = cpu_req && cpu_we && (cpu_be == 2'b00);
  assign vid_starved = vid_req && (vwait == VMAX) && !wb_hit;

  // A pending write always drains before any CPU access, which is why a CPU
  // read never needs forwarding from the buffer.
  always_comb begin
    slot = GNT_NONE;
    if (reset)                   slot = GNT_NONE;
    else if (vid_starved)        slot = GNT_VID;
    else if (wb_valid)           slot = GNT_WB;
    else if (cpu_req && !cpu_noop) slot = GNT_CPU;
    else if (vid_req)            slot = GNT_VID;
  end

  assign wb_drain = (slot == GNT_WB);
  assign wb_load  = !reset && cpu_req && cpu_we && !cpu_noop && (slot != GNT_CPU)
                    && (!wb_valid || wb_drain);
  assign cpu_accept = !reset && (cpu_noop || (slot == GNT_CPU) || wb_load);
  assign cpu_stall  = cpu_req && !cpu_accept;
  assign vid_gnt    = (slot == GNT_VID);

  posted_write_buffer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_wb (
    .clock    (clock),
    .reset    (reset),
    .load     (wb_load),
    .load_addr(cpu_addr),
    .load_data(cpu_wdata),
    .load_be  (cpu_be),
    .drain    (wb_drain),
    .cmp_addr (vid_addr),
    .valid    (wb_valid),
    .addr     (wb_addr),
    .data     (wb_data),
    .be       (wb_be),
    .hit      (wb_hit)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (slot)
      GNT_VID: begin
        mem_en   = 1'b1;
        mem_be   = BE_WORD;
        mem_addr = vid_addr;
      end
      GNT_WB: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_be    = wb_be;
        mem_addr  = wb_addr;
        mem_wdata = wb_data;
      end
      GNT_CPU: begin
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_be    = cpu_we ? cpu_be : BE_WORD;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_we ? cpu_wdata : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)                            vwait <= '0;
    else if (vid_gnt)                     vwait <= '0;
    else if (vid_req && (vwait != VMAX))  vwait <= vwait + VW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset)                          rd_owner <= OWN_NONE;
    else if (slot == GNT_VID)           rd_owner <= OWN_VID;
    else if (slot == GNT_CPU && !cpu_we) rd_owner <= OWN_CPU;
    else                                rd_owner <= OWN_NONE;
  end

  // Returns are masked while reset is held so an in-flight read never surfaces.
  assign cpu_rvalid = !reset && (rd_owner == OWN_CPU);
  assign vid_rvalid = !reset && (rd_owner == OWN_VID);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign vid_rdata  = vid_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed plus randomized bench for data_mem_arbiter against a shadow-memory reference model.
module tb_data_mem_arbiter;

  localparam int MAXW = 7;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, vid_req;
  logic [15:0] cpu_addr, cpu_wdata, vid_addr;
  logic [1:0]  cpu_be;
  logic        cpu_stall, cpu_rvalid, vid_gnt, vid_rvalid;
  logic [15:0] cpu_rdata, vid_rdata;
  logic        mem_en, mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  data_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MAX_WAIT(MAXW)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rdata(vid_rdata),
    .vid_rvalid(vid_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [15:0] ram    [256];
  logic [15:0] shadow [256];

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] d,
                                        input logic [1:0] be);
    merge = o;
    if (be[1]) merge[15:8] = d[15:8];
    if (be[0]) merge[7:0]  = d[7:0];
  endfunction

  // Synchronous-read RAM model behind the arbiter
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] = merge(ram[mem_addr[7:0]], mem_wdata, mem_be);
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  int total = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Reference model state: pending write, video wait, expected returns
  bit       m_wbv;
  int       m_wba, m_wbd;
  bit [1:0] m_wbbe;
  int       m_vw;
  bit       pc_rv, pv_rv;
  int       pc_rd, pv_rd;

  logic        s_stall, s_gnt, s_en, s_we, s_crv, s_vrv;
  logic [15:0] s_addr, s_wdata, s_crd, s_vrd;
  logic [1:0]  s_be;

  task automatic cycle(input bit rst, input bit creq, input bit cwe, input int caddr,
                       input int cwdata, input bit [1:0] cbe, input bit vreq, input int vaddr);
    bit starved, noop, vg, dr, cd, post, acc;
    reset = rst; cpu_req = creq; cpu_we = cwe; cpu_addr = 16'(caddr);
    cpu_wdata = 16'(cwdata); cpu_be = cbe; vid_req = vreq; vid_addr = 16'(vaddr);
    @(negedge clock);
    s_stall = cpu_stall; s_gnt = vid_gnt; s_en = mem_en; s_we = mem_we; s_be = mem_be;
    s_addr = mem_addr; s_wdata = mem_wdata; s_crv = cpu_rvalid; s_vrv = vid_rvalid;
    s_crd = cpu_rdata; s_vrd = vid_rdata;
    if (rst) begin
      chk("rst_stall", s_stall, creq);
      chk("rst_gnt", s_gnt, 0);
      chk("rst_mem_en", s_en, 0);
      chk("rst_cpu_rvalid", s_crv, 0);
      chk("rst_vid_rvalid", s_vrv, 0);
      m_wbv = 0; m_vw = 0; pc_rv = 0; pv_rv = 0;
    end else begin
      chk("cpu_rvalid", s_crv, pc_rv);
      if (pc_rv) chk("cpu_rdata", s_crd, pc_rd);
      chk("vid_rvalid", s_vrv, pv_rv);
      if (pv_rv) chk("vid_rdata", s_vrd, pv_rd);
      noop    = creq && cwe && (cbe == 2'b00);
      starved = vreq && (m_vw == MAXW) && !(m_wbv && vaddr == m_wba);
      vg = 0; dr = 0; cd = 0;
      if (starved)            vg = 1;
      else if (m_wbv)         dr = 1;
      else if (creq && !noop) cd = 1;
      else if (vreq)          vg = 1;
      post = creq && cwe && !noop && !cd && (!m_wbv || dr);
      acc  = noop || cd || post;
      chk("cpu_stall", s_stall, creq && !acc);
      chk("vid_gnt", s_gnt, vg);
      chk("mem_en", s_en, vg || dr || cd);
      pc_rv = 0; pv_rv = 0;
      if (dr) begin
        chk("drain_we", s_we, 1);
        chk("drain_addr", s_addr, m_wba);
        chk("drain_data", s_wdata, m_wbd);
        shadow[m_wba] = merge(shadow[m_wba], 16'(m_wbd), m_wbbe);
        m_wbv = 0;
      end
      if (cd && cwe) shadow[caddr] = merge(shadow[caddr], 16'(cwdata), cbe);
      if (cd && !cwe) begin pc_rv = 1; pc_rd = shadow[caddr]; end
      if (post) begin m_wbv = 1; m_wba = caddr; m_wbd = cwdata; m_wbbe = cbe; end
      if (vg) begin pv_rv = 1; pv_rd = shadow[vaddr]; m_vw = 0; end
      else if (vreq && m_vw < MAXW) m_vw++;
    end
    @(posedge clock); #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'($urandom); shadow[i] = ram[i];
    end
    ram[8'h40] = 16'hBEEF; shadow[8'h40] = 16'hBEEF;
    reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_be = 0;
    vid_req = 0; vid_addr = 0;

    // Reset values
    cycle(1, 0, 0, 0, 0, 2'b00, 0, 0);
    cycle(1, 0, 0, 0, 0, 2'b00, 0, 0);
    chk("rst_mem_we", s_we, 0);
    chk("rst_mem_be", s_be, 0);
    chk("rst_mem_addr", s_addr, 0);
    chk("rst_mem_wdata", s_wdata, 0);
    idle();
    chk("rst_wb_valid", dut.wb_valid, 0);
    chk("rst_vwait", dut.vwait, 0);
    chk("rst_rd_owner", dut.rd_owner, 0);

    // Lone CPU read
    cycle(0, 1, 0, 'h40, 0, 2'b11, 0, 0);
    chk("rd_stall", s_stall, 0);
    chk("rd_mem_en", s_en, 1);
    chk("rd_mem_we", s_we, 0);
    chk("rd_mem_addr", s_addr, 'h40);
    idle();
    chk("rd_rvalid", s_crv, 1);
    chk("rd_rdata", s_crd, 'hBEEF);

    // Starvation under back-to-back CPU reads
    for (int k = 0; k < 8; k++) begin
      cycle(0, 1, 0, 'h30 + k, 0, 2'b11, 1, 'h20);
      chk("starve_gnt", s_gnt, k == 7);
    end
    chk("starve_stall", s_stall, 1);
    chk("starve_vwait", dut.vwait, 0);
    idle();
    chk("starve_vrvalid", s_vrv, 1);
    chk("starve_vrdata", s_vrd, shadow[8'h20]);

    // Write posted while video wins, then read-after-write through the drain
    for (int k = 0; k < 7; k++) cycle(0, 1, 0, 'h30, 0, 2'b11, 1, 'h20);
    cycle(0, 1, 1, 'h10, 'h1234, 2'b11, 1, 'h20);
    chk("post_stall", s_stall, 0);
    chk("post_gnt", s_gnt, 1);
    chk("post_wb_valid", dut.wb_valid, 1);
    cycle(0, 1, 0, 'h10, 0, 2'b11, 0, 0);
    chk("raw_stall", s_stall, 1);
    chk("drain_mem_we", s_we, 1);
    chk("drain_mem_addr", s_addr, 'h10);
    chk("drain_mem_wdata", s_wdata, 'h1234);
    cycle(0, 1, 0, 'h10, 0, 2'b11, 0, 0);
    chk("raw_issue_stall", s_stall, 0);
    chk("raw_issue_we", s_we, 0);
    idle();
    chk("raw_rdata", s_crd, 'h1234);

    // Buffer full and not draining while video starved
    for (int k = 0; k < 7; k++) cycle(0, 1, 0, 'h31, 0, 2'b11, 1, 'h20);
    cycle(0, 1, 1, 'h60, 'hA000, 2'b11, 1, 'h20);
    for (int k = 1; k < 8; k++) begin
      cycle(0, 1, 1, 'h60 + k, 'hA000 + k, 2'b11, 1, 'h20);
      chk("chain_stall", s_stall, 0);
    end
    cycle(0, 1, 1, 'h68, 'hA008, 2'b01, 1, 'h20);
    chk("full_stall", s_stall, 1);
    chk("full_gnt", s_gnt, 1);
    cycle(0, 1, 1, 'h68, 'hA008, 2'b01, 1, 'h20);
    chk("full_post_stall", s_stall, 0);
    chk("full_drain_addr", s_addr, 'h67);
    chk("full_drain_data", s_wdata, 'hA007);
    chk("full_wb_valid", dut.wb_valid, 1);
    idle(); idle();

    // Reset the cycle after a video read issues
    cycle(0, 0, 0, 0, 0, 2'b00, 1, 'h21);
    chk("vrd_gnt", s_gnt, 1);
    cycle(1, 0, 0, 0, 0, 2'b00, 0, 0);
    chk("rstrd_vrvalid", s_vrv, 0);
    idle();
    chk("after_rst_vrvalid", s_vrv, 0);
    chk("after_rst_en", s_en, 0);
    chk("after_rst_wb_valid", dut.wb_valid, 0);

    // Randomized traffic with address collisions and zero byte enables
    for (int n = 0; n < 600; n++) begin
      cycle(0, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
            int'($urandom_range(0, 65535)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 15));
    end
    idle(); idle(); idle();
    for (int i = 0; i < 256; i++) chk("ram_final", ram[i], shadow[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
